// File: rtl/axi_write_join.sv
// axi_write_join
// Joins the independent AXI write-address (AW) and write-data (W) channels
// into one combined write request for the downstream AXI-to-UMI write stage.
// Only one transaction is in flight at a time:
//   COLLECT : gather one AW beat and one W beat, in any order and with any gap
//   SEND    : present the joined address/data/strobes until downstream accepts
//   RESP    : return an OKAY B response, then go back to collecting
// A synchronous reset drops any partially collected or unacknowledged
// transaction without issuing a B response for it.

module axi_write_join (
   input  logic         clk,
   input  logic         rst,

   // AXI write-address channel
   input  logic         s_awvalid,
   output logic         s_awready,
   input  logic [63:0]  s_awaddr,

   // AXI write-data channel
   input  logic         s_wvalid,
   output logic         s_wready,
   input  logic [255:0] s_wdata,
   input  logic [31:0]  s_wstrb,

   // AXI write-response channel
   output logic         s_bvalid,
   input  logic         s_bready,
   output logic [1:0]   s_bresp,

   // Joined write towards the downstream stage
   output logic         m_valid,
   input  logic         m_ready,
   output logic [63:0]  m_addr,
   output logic [255:0] m_data,
   output logic [31:0]  m_strb
);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SEND    = 2'd1,
      RESP    = 2'd2
   } state_t;

   state_t         state;

   // One-entry slots for each incoming channel
   logic           aw_full;
   logic           w_full;
   logic [63:0]    addr_q;
   logic [255:0]   data_q;
   logic [31:0]    strb_q;

   // Registered handshake outputs, kept in step with the state register
   logic           m_valid_q;
   logic           b_valid_q;

   // Handshake and slot-completion terms
   logic           in_collect;
   logic           aw_hs;
   logic           w_hs;
   logic           aw_done;
   logic           w_done;
   logic           m_hs;
   logic           b_hs;

   assign in_collect = (state == COLLECT);

   // Ready only while collecting and only for a slot that is still empty.
   // Gated by rst so that nothing is advertised while reset is held.
   assign s_awready  = ~rst & in_collect & ~aw_full;
   assign s_wready   = ~rst & in_collect & ~w_full;

   assign aw_hs      = s_awvalid & s_awready;
   assign w_hs       = s_wvalid  & s_wready;

   // A slot counts as full if it already was or is being filled this cycle
   assign aw_done    = aw_full | aw_hs;
   assign w_done     = w_full  | w_hs;

   assign m_valid    = ~rst & m_valid_q;
   assign s_bvalid   = ~rst & b_valid_q;

   // m_valid_q / b_valid_q are only ever set in SEND / RESP, so these
   // handshakes automatically ignore stray ready signals in other states
   assign m_hs       = m_valid & m_ready;
   assign b_hs       = s_bvalid & s_bready;

   // Every write is completed successfully
   assign s_bresp    = 2'b00;

   assign m_addr     = addr_q;
   assign m_data     = data_q;
   assign m_strb     = strb_q;

   // Transaction sequencer: slot flags, state and registered valid outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= COLLECT;
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         m_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (aw_hs) begin
                  aw_full <= 1'b1;
               end
               if (w_hs) begin
                  w_full <= 1'b1;
               end
               if (aw_done && w_done) begin
                  state     <= SEND;
                  m_valid_q <= 1'b1;
               end
            end

            SEND: begin
               if (m_hs) begin
                  state     <= RESP;
                  m_valid_q <= 1'b0;
                  b_valid_q <= 1'b1;
                  aw_full   <= 1'b0;
                  w_full    <= 1'b0;
               end
            end

            RESP: begin
               if (b_hs) begin
                  state     <= COLLECT;
                  b_valid_q <= 1'b0;
               end
            end

            default: begin
               state     <= COLLECT;
               aw_full   <= 1'b0;
               w_full    <= 1'b0;
               m_valid_q <= 1'b0;
               b_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Capture address, data and strobes verbatim on their own handshakes
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= 64'd0;
         data_q <= 256'd0;
         strb_q <= 32'd0;
      end else begin
         if (aw_hs) begin
            addr_q <= s_awaddr;
         end
         if (w_hs) begin
            data_q <= s_wdata;
            strb_q <= s_wstrb;
         end
      end
   end

endmodule

// File: tb/tb_axi_write_join.sv
// tb_axi_write_join
// Directed cycle-accurate sequences for the latency chain, stalls, ordering
// and reset abort, followed by a table of ten transactions pushed through
// with random AW/W skew and random ready stalls. Expected joined writes are
// queued at AW acceptance and popped when the downstream handshake occurs.

module tb_axi_write_join;

   logic         clk;
   logic         rst;
   logic         s_awvalid;
   logic         s_awready;
   logic [63:0]  s_awaddr;
   logic         s_wvalid;
   logic         s_wready;
   logic [255:0] s_wdata;
   logic [31:0]  s_wstrb;
   logic         s_bvalid;
   logic         s_bready;
   logic [1:0]   s_bresp;
   logic         m_valid;
   logic         m_ready;
   logic [63:0]  m_addr;
   logic [255:0] m_data;
   logic [31:0]  m_strb;

   int total;
   int bad;

   localparam int NV = 10;

   typedef struct {
      logic [63:0]  addr;
      logic [255:0] data;
      logic [31:0]  strb;
      int           aw_delay;
      int           w_delay;
      logic [63:0]  exp_addr;
      logic [255:0] exp_data;
      logic [31:0]  exp_strb;
   } vec_t;

   typedef struct {
      logic [63:0]  addr;
      logic [255:0] data;
      logic [31:0]  strb;
   } exp_t;

   vec_t vec [NV];
   exp_t sb [$];

   int  m_count;
   int  b_count;
   bit  rand_done;

   localparam logic [255:0] DATA_A5  = {32{8'hA5}};
   localparam logic [255:0] JUNK_D   = {8{32'hDEADBEEF}};

   axi_write_join dut (
      .clk       (clk),
      .rst       (rst),
      .s_awvalid (s_awvalid),
      .s_awready (s_awready),
      .s_awaddr  (s_awaddr),
      .s_wvalid  (s_wvalid),
      .s_wready  (s_wready),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_bvalid  (s_bvalid),
      .s_bready  (s_bready),
      .s_bresp   (s_bresp),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_addr    (m_addr),
      .m_data    (m_data),
      .m_strb    (m_strb)
   );

   // Free-running 10-time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge, where inputs are driven
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Move to the next cycle, drive every input, then settle for checking
   task automatic applyStimulus(input logic r,
                                input logic awv, input logic [63:0] aa,
                                input logic wv, input logic [255:0] wd, input logic [31:0] ws,
                                input logic mr, input logic br);
      tick();
      rst       = r;
      s_awvalid = awv;
      s_awaddr  = aa;
      s_wvalid  = wv;
      s_wdata   = wd;
      s_wstrb   = ws;
      m_ready   = mr;
      s_bready  = br;
      #1;
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) begin
         r[k*32 +: 32] = $urandom;
      end
      return r;
   endfunction

   // Main test sequence
   initial begin
      total     = 0;
      bad       = 0;
      m_count   = 0;
      b_count   = 0;
      rand_done = 1'b0;
      rst       = 1'b1;
      s_awvalid = 1'b0;
      s_awaddr  = '0;
      s_wvalid  = 1'b0;
      s_wdata   = '0;
      s_wstrb   = '0;
      m_ready   = 1'b0;
      s_bready  = 1'b0;

      // Table of transactions for the randomized back-to-back phase
      for (int i = 0; i < NV; i++) begin
         vec[i].addr     = {$urandom, $urandom};
         vec[i].data     = rand256();
         vec[i].strb     = $urandom;
         vec[i].aw_delay = int'($urandom_range(0, 3));
         vec[i].w_delay  = int'($urandom_range(0, 3));
      end
      vec[0].addr = 64'hFFFF_FFFF_FFFF_FFFF;
      vec[0].data = {256{1'b1}};
      vec[0].strb = 32'hFFFF_FFFF;
      vec[1].addr = 64'h0;
      vec[1].data = 256'h0;
      vec[1].strb = 32'h0;
      for (int i = 0; i < NV; i++) begin
         vec[i].exp_addr = vec[i].addr;
         vec[i].exp_data = vec[i].data;
         vec[i].exp_strb = vec[i].strb;
      end

      $display("[TB] reset behaviour");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("rst_awready", s_awready, 0);
      checkOutput("rst_wready",  s_wready,  0);
      checkOutput("rst_bvalid",  s_bvalid,  0);
      checkOutput("rst_mvalid",  m_valid,   0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("post_rst_awready", s_awready, 1);
      checkOutput("post_rst_wready",  s_wready,  1);
      checkOutput("post_rst_mdata",   m_data,    0);

      $display("[TB] simultaneous AW and W");
      applyStimulus(0, 1, 64'h1000, 1, DATA_A5, 32'hFFFF_FFFF, 1, 1);
      checkOutput("sim_n_awready", s_awready, 1);
      checkOutput("sim_n_wready",  s_wready,  1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("sim_n1_mvalid",  m_valid,   1);
      checkOutput("sim_n1_maddr",   m_addr,    64'h1000);
      checkOutput("sim_n1_mdata",   m_data,    DATA_A5);
      checkOutput("sim_n1_mstrb",   m_strb,    32'hFFFF_FFFF);
      checkOutput("sim_n1_awready", s_awready, 0);
      checkOutput("sim_n1_bvalid",  s_bvalid,  0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("sim_n2_bvalid",  s_bvalid,  1);
      checkOutput("sim_n2_bresp",   s_bresp,   0);
      checkOutput("sim_n2_mvalid",  m_valid,   0);
      checkOutput("sim_n2_awready", s_awready, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("sim_n3_awready", s_awready, 1);
      checkOutput("sim_n3_wready",  s_wready,  1);
      checkOutput("sim_n3_bvalid",  s_bvalid,  0);

      $display("[TB] W first, AW three cycles later, then stalls");
      applyStimulus(0, 0, 0, 1, 256'h1234, 32'h0000_00FF, 0, 0);
      checkOutput("wf_n_wready", s_wready, 1);
      for (int k = 1; k <= 3; k++) begin
         if (k < 3) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
         end else begin
            applyStimulus(0, 1, 64'h2000, 0, 0, 0, 0, 0);
         end
         checkOutput("wf_wait_wready",  s_wready,  0);
         checkOutput("wf_wait_awready", s_awready, 1);
         checkOutput("wf_wait_mvalid",  m_valid,   0);
      end
      for (int j = 0; j < 5; j++) begin
         applyStimulus(0, 1, 64'hDEAD, 1, JUNK_D, 32'h5A5A_5A5A, (j == 4), 0);
         checkOutput("stall_mvalid",  m_valid,   1);
         checkOutput("stall_maddr",   m_addr,    64'h2000);
         checkOutput("stall_mdata",   m_data,    256'h1234);
         checkOutput("stall_mstrb",   m_strb,    32'h0000_00FF);
         checkOutput("stall_awready", s_awready, 0);
         checkOutput("stall_wready",  s_wready,  0);
         checkOutput("stall_bvalid",  s_bvalid,  0);
      end
      for (int j = 0; j < 4; j++) begin
         applyStimulus(0, 1, 64'hDEAD, 1, JUNK_D, 32'h5A5A_5A5A, 1, (j == 3));
         checkOutput("bstall_bvalid",  s_bvalid,  1);
         checkOutput("bstall_bresp",   s_bresp,   0);
         checkOutput("bstall_mvalid",  m_valid,   0);
         checkOutput("bstall_awready", s_awready, 0);
         checkOutput("bstall_wready",  s_wready,  0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("bdone_awready", s_awready, 1);
      checkOutput("bdone_wready",  s_wready,  1);
      checkOutput("bdone_bvalid",  s_bvalid,  0);
      checkOutput("bdone_maddr",   m_addr,    64'h2000);
      checkOutput("bdone_mdata",   m_data,    256'h1234);

      $display("[TB] reset abort after AW-only capture");
      applyStimulus(0, 1, 64'h3000, 0, 0, 0, 0, 0);
      checkOutput("ab_awready", s_awready, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("ab_awfull_awready", s_awready, 0);
      checkOutput("ab_awfull_wready",  s_wready,  1);
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("ab_rst_awready", s_awready, 0);
      checkOutput("ab_rst_wready",  s_wready,  0);
      applyStimulus(0, 0, 0, 1, 256'h5555, 32'h0000_000F, 0, 0);
      checkOutput("ab_after_awready", s_awready, 1);
      checkOutput("ab_after_wready",  s_wready,  1);
      checkOutput("ab_after_mvalid",  m_valid,   0);
      checkOutput("ab_after_bvalid",  s_bvalid,  0);
      checkOutput("ab_after_maddr",   m_addr,    0);
      applyStimulus(0, 1, 64'h4000, 0, 0, 0, 1, 1);
      checkOutput("ab_wonly_mvalid",  m_valid,   0);
      checkOutput("ab_wonly_awready", s_awready, 1);
      checkOutput("ab_wonly_wready",  s_wready,  0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("ab_send_mvalid", m_valid, 1);
      checkOutput("ab_send_maddr",  m_addr,  64'h4000);
      checkOutput("ab_send_mdata",  m_data,  256'h5555);
      checkOutput("ab_send_mstrb",  m_strb,  32'h0000_000F);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("ab_resp_bvalid", s_bvalid, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("ab_done_awready", s_awready, 1);
      checkOutput("ab_done_bvalid",  s_bvalid,  0);

      $display("[TB] randomized back-to-back transactions");
      fork
         begin : aw_driver
            bit hs;
            int guard;
            tick();
            for (int i = 0; i < NV; i++) begin
               for (int d = 0; d < vec[i].aw_delay; d++) tick();
               s_awvalid = 1'b1;
               s_awaddr  = vec[i].addr;
               hs        = 1'b0;
               guard     = 0;
               while (!hs && guard < 200) begin
                  #1;
                  hs = s_awready;
                  if (hs) begin
                     sb.push_back('{vec[i].exp_addr, vec[i].exp_data, vec[i].exp_strb});
                  end
                  tick();
                  guard++;
               end
               s_awvalid = 1'b0;
               if (!hs) checkOutput("aw_timeout", 0, 1);
            end
         end
         begin : w_driver
            bit hs;
            int guard;
            tick();
            for (int i = 0; i < NV; i++) begin
               for (int d = 0; d < vec[i].w_delay; d++) tick();
               s_wvalid = 1'b1;
               s_wdata  = vec[i].data;
               s_wstrb  = vec[i].strb;
               hs       = 1'b0;
               guard    = 0;
               while (!hs && guard < 200) begin
                  #1;
                  hs = s_wready;
                  tick();
                  guard++;
               end
               s_wvalid = 1'b0;
               if (!hs) checkOutput("w_timeout", 0, 1);
            end
         end
         begin : m_responder
            exp_t e;
            tick();
            while (!rand_done) begin
               m_ready = ($urandom_range(0, 2) != 0);
               #1;
               if (m_valid && m_ready) begin
                  if (sb.size() == 0) begin
                     checkOutput("sb_underflow", 0, 1);
                  end else begin
                     e = sb.pop_front();
                     checkOutput("rnd_addr", m_addr, e.addr);
                     checkOutput("rnd_data", m_data, e.data);
                     checkOutput("rnd_strb", m_strb, e.strb);
                  end
                  m_count++;
               end
               tick();
            end
            m_ready = 1'b0;
         end
         begin : b_responder
            tick();
            while (!rand_done) begin
               s_bready = ($urandom_range(0, 2) != 0);
               #1;
               if (s_bvalid && s_bready) begin
                  checkOutput("rnd_bresp", s_bresp, 0);
                  b_count++;
               end
               tick();
            end
            s_bready = 1'b0;
         end
         begin : watchdog
            for (int c = 0; c < 4000 && !(m_count == NV && b_count == NV); c++) tick();
            repeat (3) tick();
            rand_done = 1'b1;
         end
      join

      checkOutput("rnd_m_count",  m_count,   NV);
      checkOutput("rnd_b_count",  b_count,   NV);
      checkOutput("rnd_sb_empty", sb.size(), 0);

      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
         checkOutput("idle_bvalid",  s_bvalid,  0);
         checkOutput("idle_mvalid",  m_valid,   0);
         checkOutput("idle_awready", s_awready, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_write_join.md
AXI_WRITE_JOIN -- requirements
Module: axi_write_join

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 s_awvalid  input  1  AXI write-address valid.
REQ-005 s_awready  output  1  AXI write-address ready.
REQ-006 s_awaddr  input  64  AXI write address.
REQ-007 s_wvalid  input  1  AXI write-data valid.
REQ-008 s_wready  output  1  AXI write-data ready.
REQ-009 s_wdata  input  256  AXI write data.
REQ-010 s_wstrb  input  32  AXI byte strobes.
REQ-011 s_bvalid  output  1  AXI write-response valid.
REQ-012 s_bready  input  1  AXI write-response ready.
REQ-013 s_bresp  output  2  write response; constant 2'b00 (OKAY).
REQ-014 m_valid  output  1  joined write valid, feeding the AXI-to-UMI write stage.
REQ-015 m_ready  input  1  downstream accepts the joined write.
REQ-016 m_addr  output  64  held address.
REQ-017 m_data  output  256  held data.
REQ-018 m_strb  output  32  held strobes.

Function
REQ-019 SHALL hold one AW slot and one W slot, with flags aw_full and w_full and registers for addr, data and strb.
REQ-020 SHALL implement three states: COLLECT, SEND and RESP; only one transaction is outstanding at any time.
REQ-021 COLLECT: s_awready = ~aw_full and s_wready = ~w_full, both combinational from registered state.
REQ-022 An AW handshake (s_awvalid & s_awready) SHALL load s_awaddr and set aw_full.
REQ-023 A W handshake SHALL load s_wdata and s_wstrb and set w_full.
REQ-024 AW and W SHALL be accepted in either order, in the same cycle or in different cycles, with any gap between them.
REQ-025 COLLECT -> SEND on the edge at which both slots are full, counting a handshake in that same cycle.
- Latency: the last of the AW/W handshakes in cycle N gives m_valid = 1 in cycle N+1.
REQ-026 SEND: m_valid = 1, and m_addr/m_data/m_strb SHALL be stable until accepted; s_awready = s_wready = 0.
REQ-027 SEND -> RESP on m_valid & m_ready; aw_full and w_full clear on the same edge.
- m_valid SHALL NOT drop before m_ready is seen.
REQ-028 RESP: s_bvalid = 1 and s_bresp = 2'b00; s_awready = s_wready = 0; m_valid = 0.
REQ-029 s_bvalid SHALL stay asserted until s_bready; RESP -> COLLECT on s_bvalid & s_bready.
REQ-030 s_bready asserted outside RESP SHALL be ignored; m_ready asserted outside SEND SHALL be ignored.
REQ-031 Timing chain: m_ready in cycle M gives s_bvalid in M+1; s_bready in cycle K gives s_awready = s_wready = 1 in K+1.
- Minimum 3 cycles per transaction.
REQ-032 m_addr/m_data/m_strb SHALL change only on an AW/W handshake.
- Outside SEND their values are don't-care but SHALL be deterministic.
REQ-033 s_wdata and s_awaddr SHALL be captured verbatim: no alignment, masking or size logic.

Reset
REQ-034 While rst = 1, the following SHALL read 0: s_awready, s_wready, s_bvalid, m_valid.
REQ-035 On any edge with rst = 1: state -> COLLECT, aw_full = w_full = 0, data registers -> 0.
- This SHALL abort any partially collected or unacknowledged transaction, with no B response issued for it.
REQ-036 In the first cycle after rst deasserts, s_awready = s_wready = 1.

Verification
REQ-037 Simultaneous AW (addr 0x1000) and W (data 0xA5..A5, strb all-ones) in cycle N, m_ready = 1:
- m_valid in N+1 with m_addr = 0x1000 and matching data;
- s_bvalid in N+2; s_bready = 1 gives s_awready = 1 in N+3.
REQ-038 W first (data 0x1234, cycle N), AW (0x2000) in N+3:
- s_wready = 0 in N+1..N+3 while s_awready = 1;
- m_valid in N+4 with m_addr = 0x2000 and m_data = 0x1234.
REQ-039 m_ready held 0 for 5 cycles in SEND: m_valid and fields stable all 5 cycles; s_awready = s_wready = 0.
REQ-040 s_bready held 0 for 4 cycles in RESP: s_bvalid stays 1 with s_bresp = 00; no new AW/W accepted; m_valid = 0.
REQ-041 rst pulsed for one cycle after AW-only capture:
- state returns to COLLECT, aw_full = 0, no m_valid and no s_bvalid;
- the next AW+W pair completes normally with the new address.
REQ-042 10 back-to-back transactions with random AW/W skew (0..3 cycles) and random ready stalls:
- downstream receives all 10 in order with exact addr/data/strb;
- exactly 10 B responses are issued.
